// File: rtl/regfile_sb.sv
// Multi-port register file with a per-register outstanding-write scoreboard.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_sb #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int NR = 2,
  parameter int CW = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NR*AW-1:0]   rd_addr,
  output logic [NR*DW-1:0]   rd_data,
  output logic [NR-1:0]      rd_busy,
  input  logic               w0_en,
  input  logic [AW-1:0]      w0_addr,
  input  logic [DW-1:0]      w0_data,
  input  logic               w1_en,
  input  logic [AW-1:0]      w1_addr,
  input  logic [DW-1:0]      w1_data,
  input  logic               alloc_en,
  input  logic [AW-1:0]      alloc_addr,
  output logic               alloc_full
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  // Register 0 is hardwired to zero, so no storage is kept for it.
  logic [DW-1:0] regs_q [1:DEPTH-1];
  logic [DW-1:0] regs_d [1:DEPTH-1];
  logic [CW-1:0] cnt_q  [1:DEPTH-1];
  logic [CW-1:0] cnt_d  [1:DEPTH-1];
  logic [1:0]    dec    [1:DEPTH-1];
  logic          inc    [1:DEPTH-1];

  logic w0_hit;
  logic w1_hit;
  logic alloc_hit;

  assign w0_hit     = w0_en && (w0_addr != '0);
  assign w1_hit     = w1_en && (w1_addr != '0);
  assign alloc_full = (alloc_addr != '0) && (cnt_q[alloc_addr] == CNT_MAX);
  assign alloc_hit  = alloc_en && (alloc_addr != '0) && !alloc_full;

  // Net counter change is inc - dec, clamped at zero; inc is blocked at max so no wrap.
  always_comb begin
    for (int r = 1; r < DEPTH; r++) begin
      inc[r] = alloc_hit && (alloc_addr == AW'(r));
      dec[r] = 2'(w0_hit && (w0_addr == AW'(r))) + 2'(w1_hit && (w1_addr == AW'(r)));
      regs_d[r] = regs_q[r];
      if (w0_hit && (w0_addr == AW'(r))) regs_d[r] = w0_data;
      if (w1_hit && (w1_addr == AW'(r))) regs_d[r] = w1_data;
      if (((CW+2)'(cnt_q[r]) + (CW+2)'(inc[r])) > (CW+2)'(dec[r]))
        cnt_d[r] = CW'((CW+2)'(cnt_q[r]) + (CW+2)'(inc[r]) - (CW+2)'(dec[r]));
      else
        cnt_d[r] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 1; r < DEPTH; r++) begin
        regs_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
    end else begin
      for (int r = 1; r < DEPTH; r++) begin
        regs_q[r] <= regs_d[r];
        cnt_q[r]  <= cnt_d[r];
      end
    end
  end

  for (genvar k = 0; k < NR; k++) begin : g_rd
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          busy;

    assign addr = rd_addr[k*AW +: AW];

`ifdef REGFILE_BYPASS_EN
    // Busy uses the post-write count, so a releasing write clears it in its own cycle.
    assign data = (addr == '0)                  ? '0      :
                  (w1_hit && (w1_addr == addr)) ? w1_data :
                  (w0_hit && (w0_addr == addr)) ? w0_data :
                                                  regs_q[addr];
    assign busy = (addr != '0) && ((CW+2)'(cnt_q[addr]) > (CW+2)'(dec[addr]));
`else
    assign data = (addr == '0) ? '0 : regs_q[addr];
    assign busy = (addr != '0) && (cnt_q[addr] != '0);
`endif

    assign rd_data[k*DW +: DW] = data;
    assign rd_busy[k]          = busy;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed table plus randomized traffic
// checked against an array-based scoreboard model (honours REGFILE_BYPASS_EN).
module tb_regfile_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int CW = 2;
  localparam int DEPTH = 2 ** AW;
  localparam int CNT_MAX = (2 ** CW) - 1;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_busy;
  logic             w0_en;
  logic [AW-1:0]    w0_addr;
  logic [DW-1:0]    w0_data;
  logic             w1_en;
  logic [AW-1:0]    w1_addr;
  logic [DW-1:0]    w1_data;
  logic             alloc_en;
  logic [AW-1:0]    alloc_addr;
  logic             alloc_full;

  regfile_sb #(.DW(DW), .AW(AW), .NR(NR), .CW(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .w0_en      (w0_en),
    .w0_addr    (w0_addr),
    .w0_data    (w0_data),
    .w1_en      (w1_en),
    .w1_addr    (w1_addr),
    .w1_data    (w1_data),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .alloc_full (alloc_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          w0_en;
    logic [AW-1:0] w0_addr;
    logic [DW-1:0] w0_data;
    logic          w1_en;
    logic [AW-1:0] w1_addr;
    logic [DW-1:0] w1_data;
    logic          alloc_en;
    logic [AW-1:0] alloc_addr;
    logic [AW-1:0] rd0;
    logic [AW-1:0] rd1;
    logic          chk;
    logic [DW-1:0] exp_d0;
    logic [1:0]    exp_busy;
    logic          exp_full;
  } vec_t;

  logic [DW-1:0] m_regs [DEPTH];
  int            m_cnt  [DEPTH];
  int            n_checks;
  int            n_fail;

  function automatic vec_t mk(logic rst, logic w0e, logic [AW-1:0] w0a, logic [DW-1:0] w0d,
                              logic w1e, logic [AW-1:0] w1a, logic [DW-1:0] w1d,
                              logic ae, logic [AW-1:0] aa, logic [AW-1:0] r0, logic [AW-1:0] r1,
                              logic [DW-1:0] ed0, logic [1:0] eb, logic ef);
    vec_t v;
    v.rst = rst;  v.w0_en = w0e; v.w0_addr = w0a; v.w0_data = w0d;
    v.w1_en = w1e; v.w1_addr = w1a; v.w1_data = w1d;
    v.alloc_en = ae; v.alloc_addr = aa; v.rd0 = r0; v.rd1 = r1;
    v.chk = 1'b1; v.exp_d0 = ed0; v.exp_busy = eb; v.exp_full = ef;
    return v;
  endfunction

  function automatic int writes_to(logic [AW-1:0] a, vec_t v);
    int n;
    n = 0;
    if (a != 0 && v.w0_en && v.w0_addr == a) n++;
    if (a != 0 && v.w1_en && v.w1_addr == a) n++;
    return n;
  endfunction

  function automatic logic [DW-1:0] pred_data(logic [AW-1:0] a, vec_t v);
    if (a == 0) return '0;
    if (BYP && v.w1_en && v.w1_addr == a) return v.w1_data;
    if (BYP && v.w0_en && v.w0_addr == a) return v.w0_data;
    return m_regs[a];
  endfunction

  function automatic logic pred_busy(logic [AW-1:0] a, vec_t v);
    int c;
    if (a == 0) return 1'b0;
    c = m_cnt[a];
    if (BYP) c = c - writes_to(a, v);
    return c > 0;
  endfunction

  function automatic logic pred_full(vec_t v);
    return (v.alloc_addr != 0) && (m_cnt[v.alloc_addr] == CNT_MAX);
  endfunction

  task automatic model_update(input vec_t v);
    int nc [DEPTH];
    logic full;
    full = pred_full(v);
    if (v.rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        m_regs[r] = '0;
        m_cnt[r]  = 0;
      end
    end else begin
      for (int r = 0; r < DEPTH; r++) nc[r] = m_cnt[r];
      if (v.alloc_en && v.alloc_addr != 0 && !full) nc[v.alloc_addr]++;
      if (v.w0_en && v.w0_addr != 0) nc[v.w0_addr]--;
      if (v.w1_en && v.w1_addr != 0) nc[v.w1_addr]--;
      for (int r = 0; r < DEPTH; r++) m_cnt[r] = (nc[r] < 0) ? 0 : nc[r];
      if (v.w0_en && v.w0_addr != 0) m_regs[v.w0_addr] = v.w0_data;
      if (v.w1_en && v.w1_addr != 0) m_regs[v.w1_addr] = v.w1_data;
    end
  endtask

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    reset      = v.rst;
    w0_en      = v.w0_en;
    w0_addr    = v.w0_addr;
    w0_data    = v.w0_data;
    w1_en      = v.w1_en;
    w1_addr    = v.w1_addr;
    w1_data    = v.w1_data;
    alloc_en   = v.alloc_en;
    alloc_addr = v.alloc_addr;
    rd_addr    = {v.rd1, v.rd0};
  endtask

  // One clock: drive just after posedge, compare at negedge, advance model at the next posedge.
  task automatic run_cycle(input string tag, input vec_t v);
    logic [63:0] exp_data;
    logic [1:0]  exp_busy;
    apply_stimulus(v);
    @(negedge clk);
    exp_data = {pred_data(v.rd1, v), pred_data(v.rd0, v)};
    exp_busy = {pred_busy(v.rd1, v), pred_busy(v.rd0, v)};
    check_output({tag, "_model_rd_data"}, 64'(rd_data), exp_data);
    check_output({tag, "_model_rd_busy"}, 64'(rd_busy), 64'(exp_busy));
    check_output({tag, "_model_alloc_full"}, 64'(alloc_full), 64'(pred_full(v)));
    if (v.chk) begin
      check_output({tag, "_rd_data0"}, 64'(rd_data[DW-1:0]), 64'(v.exp_d0));
      check_output({tag, "_rd_busy"}, 64'(rd_busy), 64'(v.exp_busy));
      check_output({tag, "_alloc_full"}, 64'(alloc_full), 64'(v.exp_full));
    end
    @(posedge clk);
    model_update(v);
    #1;
  endtask

  initial begin
    vec_t tab[$];
    vec_t v;
    n_checks = 0;
    n_fail   = 0;

    v = mk(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0, '0, '0, 2'b00, 1'b0);
    apply_stimulus(v);
    @(posedge clk);
    model_update(v);
    #1;

    for (int i = 0; i < DEPTH; i++)
      run_cycle($sformatf("sweep%0d", i),
                mk(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, AW'(i), AW'(i), '0, 2'b00, 1'b0));

    // rst w0e w0a w0d          w1e w1a w1d          ae aa  rd0 rd1 exp_d0                exp_busy              full
    tab.push_back(mk(1, 1, 5, 32'hDEADBEEF, 0, 0, 0,            0, 0, 6, 0, 0,                     2'b00,                0));
    tab.push_back(mk(0, 0, 0, 0,            0, 0, 0,            0, 0, 5, 0, 0,                     2'b00,                0));
    tab.push_back(mk(0, 1, 3, 32'h11,       1, 3, 32'h22,       0, 0, 3, 3, BYP ? 32'h22 : 32'h0,  2'b00,                0));
    tab.push_back(mk(0, 0, 0, 0,            0, 0, 0,            0, 0, 3, 3, 32'h22,                2'b00,                0));
    tab.push_back(mk(0, 1, 0, 32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 0,                     2'b00,                0));
    tab.push_back(mk(0, 0, 0, 0,            0, 0, 0,            0, 0, 0, 0, 0,                     2'b00,                0));
    tab.push_back(mk(0, 0, 0, 0,            0, 0, 0,            1, 7, 7, 7, 0,                     2'b00,                0));
    tab.push_back(mk(0, 0, 0, 0,            0, 0, 0,            1, 7, 7, 7, 0,                     2'b11,                0));
    tab.push_back(mk(0, 0, 0, 0,            0, 0, 0,            1, 7, 7, 7, 0,                     2'b11,                0));
    tab.push_back(mk(0, 0, 0, 0,            0, 0, 0,            1, 7, 7, 7, 0,                     2'b11,                1));
    tab.push_back(mk(0, 1, 7, 32'hA1,       0, 0, 0,            0, 7, 7, 7, BYP ? 32'hA1 : 32'h0,  2'b11,                1));
    tab.push_back(mk(0, 1, 7, 32'hA2,       0, 0, 0,            0, 7, 7, 7, BYP ? 32'hA2 : 32'hA1, 2'b11,                0));
    tab.push_back(mk(0, 0, 0, 0,            1, 7, 32'hA3,       0, 7, 7, 7, BYP ? 32'hA3 : 32'hA2, BYP ? 2'b00 : 2'b11,  0));
    tab.push_back(mk(0, 1, 7, 32'hA4,       0, 0, 0,            0, 7, 7, 7, BYP ? 32'hA4 : 32'hA3, 2'b00,                0));
    tab.push_back(mk(0, 0, 0, 0,            0, 0, 0,            0, 7, 7, 7, 32'hA4,                2'b00,                0));
    tab.push_back(mk(0, 0, 0, 0,            0, 0, 0,            1, 9, 9, 9, 0,                     2'b00,                0));
    tab.push_back(mk(0, 1, 9, 32'h5,        0, 0, 0,            1, 9, 9, 9, BYP ? 32'h5 : 32'h0,   BYP ? 2'b00 : 2'b11,  0));
    tab.push_back(mk(0, 0, 0, 0,            1, 9, 32'h6,        0, 9, 9, 9, BYP ? 32'h6 : 32'h5,   BYP ? 2'b00 : 2'b11,  0));
    tab.push_back(mk(0, 0, 0, 0,            0, 0, 0,            0, 9, 9, 9, 32'h6,                 2'b00,                0));
    tab.push_back(mk(0, 0, 0, 0,            0, 0, 0,            1, 4, 4, 9, 0,                     2'b00,                0));
    tab.push_back(mk(0, 0, 0, 0,            0, 0, 0,            1, 4, 4, 9, 0,                     2'b01,                0));
    tab.push_back(mk(0, 1, 4, 32'h77,       0, 0, 0,            0, 4, 4, 9, BYP ? 32'h77 : 32'h0,  2'b01,                0));
    tab.push_back(mk(1, 0, 0, 0,            0, 0, 0,            1, 4, 4, 9, 32'h77,                2'b01,                0));
    tab.push_back(mk(0, 0, 0, 0,            0, 0, 0,            0, 4, 4, 9, 0,                     2'b00,                0));
    tab.push_back(mk(0, 1, 4, 32'h88,       0, 0, 0,            0, 4, 4, 9, BYP ? 32'h88 : 32'h0,  2'b00,                0));
    tab.push_back(mk(0, 0, 0, 0,            0, 0, 0,            0, 4, 4, 9, 32'h88,                2'b00,                0));

    for (int i = 0; i < tab.size(); i++) run_cycle($sformatf("row%0d", i), tab[i]);

    // Narrow address range forces port collisions, counter saturation and floor-at-zero.
    for (int i = 0; i < 600; i++) begin
      v.rst        = ($urandom_range(0, 59) == 0);
      v.w0_en      = ($urandom_range(0, 2) == 0);
      v.w0_addr    = AW'($urandom_range(0, 7));
      v.w0_data    = $urandom;
      v.w1_en      = ($urandom_range(0, 3) == 0);
      v.w1_addr    = AW'($urandom_range(0, 7));
      v.w1_data    = $urandom;
      v.alloc_en   = ($urandom_range(0, 1) == 0);
      v.alloc_addr = AW'($urandom_range(0, 7));
      v.rd0        = AW'($urandom_range(0, 7));
      v.rd1        = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, DEPTH - 1)) : AW'($urandom_range(0, 7));
      v.chk        = 1'b0;
      v.exp_d0     = '0;
      v.exp_busy   = '0;
      v.exp_full   = 1'b0;
      run_cycle($sformatf("rand%0d", i), v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
